// File: rtl/mio_bus_arbiter_if.sv
// Requester, shared-bus and status signals of the two-master MIO bus arbiter.
// The arbiter takes the master view; the requesters and the bus slave take the slave view.
interface mio_bus_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              r0_req;
   logic              r0_we;
   logic [DATA_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_ready;
   logic              r0_err;
   logic [DATA_W-1:0] r0_rdata;

   logic              r1_req;
   logic              r1_we;
   logic [DATA_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_ready;
   logic              r1_err;
   logic [DATA_W-1:0] r1_rdata;

   logic              bus_en;
   logic              bus_we;
   logic [DATA_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;

   logic              owner;
   logic              busy;

   modport master (
      input  r0_req, r0_we, r0_addr, r0_wdata,
      output r0_ready, r0_err, r0_rdata,
      input  r1_req, r1_we, r1_addr, r1_wdata,
      output r1_ready, r1_err, r1_rdata,
      output bus_en, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack,
      output owner, busy
   );

   modport slave (
      output r0_req, r0_we, r0_addr, r0_wdata,
      input  r0_ready, r0_err, r0_rdata,
      output r1_req, r1_we, r1_addr, r1_wdata,
      input  r1_ready, r1_err, r1_rdata,
      input  bus_en, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack,
      input  owner, busy
   );
endinterface

// File: rtl/mio_bus_arbiter.sv
// Two-requester round-robin arbiter for a shared memory/MIO bus with an ack timeout.
// One access runs IDLE -> BUSY -> DONE; completion is a one-cycle ready pulse to the owner.
module mio_bus_arbiter #(
   parameter int TIMEOUT = 15,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   mio_bus_arbiter_if.master mio
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t            state;
   logic [7:0]        cnt;
   logic              last_grant;
   logic              owner_q;
   logic              bus_en_q;
   logic              busy_q;
   logic [1:0]        ready_q;
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_rdata;

   logic              lat_we;
   logic [DATA_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              any_req;
   logic              winner;
   logic              sel_we;
   logic [DATA_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // A lone request always wins; a tie goes to whoever was not granted last.
   function automatic logic pick_winner(input logic req0, input logic req1,
                                        input logic last);
      if (req0 && req1)
         return ~last;
      else if (req1)
         return 1'b1;
      else
         return 1'b0;
   endfunction

   always_comb begin
      any_req   = mio.r0_req | mio.r1_req;
      winner    = pick_winner(mio.r0_req, mio.r1_req, last_grant);
      sel_we    = mio.r0_we;
      sel_addr  = mio.r0_addr;
      sel_wdata = mio.r0_wdata;
      if (winner) begin
         sel_we    = mio.r1_we;
         sel_addr  = mio.r1_addr;
         sel_wdata = mio.r1_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         last_grant <= 1'b1;
         owner_q    <= 1'b0;
         bus_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 2'b00;
         rsp_err    <= 1'b0;
      end else begin
         ready_q <= 2'b00;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state      <= BUSY;
                  owner_q    <= winner;
                  last_grant <= winner;
                  lat_we     <= sel_we;
                  lat_addr   <= sel_addr;
                  lat_wdata  <= sel_wdata;
                  cnt        <= 8'd1;
                  bus_en_q   <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            BUSY: begin
               // Ack is checked first so an ack on the final allowed cycle still succeeds.
               if (mio.bus_ack) begin
                  state            <= DONE;
                  rsp_rdata        <= lat_we ? '0 : mio.bus_rdata;
                  rsp_err          <= 1'b0;
                  ready_q[owner_q] <= 1'b1;
                  bus_en_q         <= 1'b0;
               end else if (cnt == TMO) begin
                  state            <= DONE;
                  rsp_rdata        <= '0;
                  rsp_err          <= 1'b1;
                  ready_q[owner_q] <= 1'b1;
                  bus_en_q         <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus_en_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   // Response and bus data are gated so idle or non-owning outputs read as zero.
   assign mio.r0_ready  = ready_q[0];
   assign mio.r0_err    = ready_q[0] & rsp_err;
   assign mio.r0_rdata  = ready_q[0] ? rsp_rdata : '0;
   assign mio.r1_ready  = ready_q[1];
   assign mio.r1_err    = ready_q[1] & rsp_err;
   assign mio.r1_rdata  = ready_q[1] ? rsp_rdata : '0;

   assign mio.bus_en    = bus_en_q;
   assign mio.bus_we    = bus_en_q & lat_we;
   assign mio.bus_addr  = bus_en_q ? lat_addr : '0;
   assign mio.bus_wdata = bus_en_q ? lat_wdata : '0;

   assign mio.owner     = owner_q;
   assign mio.busy      = busy_q;
endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: instance A uses the default timeout, instance B uses 4.
module tb_mio_bus_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mio_bus_arbiter_if #(.DATA_W(32)) ifa ();
   mio_bus_arbiter_if #(.DATA_W(32)) ifb ();

   mio_bus_arbiter #(.TIMEOUT(15), .DATA_W(32)) dut_a (.clk(clk), .rst(rst), .mio(ifa.master));
   mio_bus_arbiter #(.TIMEOUT(4),  .DATA_W(32)) dut_b (.clk(clk), .rst(rst), .mio(ifb.master));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ifa.r0_req = 0; ifa.r0_we = 0; ifa.r0_addr = 0; ifa.r0_wdata = 0;
      ifa.r1_req = 0; ifa.r1_we = 0; ifa.r1_addr = 0; ifa.r1_wdata = 0;
      ifa.bus_rdata = 0; ifa.bus_ack = 0;
      ifb.r0_req = 0; ifb.r0_we = 0; ifb.r0_addr = 0; ifb.r0_wdata = 0;
      ifb.r1_req = 0; ifb.r1_we = 0; ifb.r1_addr = 0; ifb.r1_wdata = 0;
      ifb.bus_rdata = 0; ifb.bus_ack = 0;

      tick(); tick();
      check("rst_bus_en", ifa.bus_en, 0);
      check("rst_busy", ifa.busy, 0);
      check("rst_owner", ifa.owner, 0);
      check("rst_r0_ready", ifa.r0_ready, 0);
      check("rst_r1_ready", ifa.r1_ready, 0);
      check("rst_r0_rdata", ifa.r0_rdata, 0);
      check("rst_r0_err", ifa.r0_err, 0);
      check("rst_bus_addr", ifa.bus_addr, 0);
      rst = 0;
      tick();
      check("idle_no_req", ifa.busy, 0);

      // Single read, ack in first BUSY cycle.
      ifa.r0_req = 1; ifa.r0_we = 0; ifa.r0_addr = 32'h0000_0010;
      ifa.bus_rdata = 32'hDEAD_BEEF; ifa.bus_ack = 1;
      tick();
      check("rd_bus_en", ifa.bus_en, 1);
      check("rd_bus_addr", ifa.bus_addr, 32'h10);
      check("rd_bus_we", ifa.bus_we, 0);
      check("rd_busy", ifa.busy, 1);
      check("rd_early_ready", ifa.r0_ready, 0);
      ifa.r0_req = 0;
      tick();
      check("rd_ready", ifa.r0_ready, 1);
      check("rd_rdata", ifa.r0_rdata, 32'hDEAD_BEEF);
      check("rd_err", ifa.r0_err, 0);
      check("rd_r1_ready", ifa.r1_ready, 0);
      check("rd_r1_rdata", ifa.r1_rdata, 0);
      check("rd_done_bus_en", ifa.bus_en, 0);
      check("rd_done_busy", ifa.busy, 1);
      ifa.bus_ack = 0;
      tick();
      check("rd_idle_ready", ifa.r0_ready, 0);
      check("rd_idle_busy", ifa.busy, 0);

      // Contention from reset with ack always high: grants 0,1,0,1.
      rst = 1;
      tick();
      rst = 0;
      ifa.r0_req = 1; ifa.r0_we = 0; ifa.r0_addr = 32'h0000_0100;
      ifa.r1_req = 1; ifa.r1_we = 0; ifa.r1_addr = 32'h0000_0200;
      ifa.bus_rdata = 32'h5555_AAAA; ifa.bus_ack = 1;
      for (int k = 0; k < 4; k++) begin
         logic exp_own;
         exp_own = k[0];
         tick();
         check("rr_owner", ifa.owner, exp_own);
         check("rr_bus_en", ifa.bus_en, 1);
         check("rr_bus_addr", ifa.bus_addr, exp_own ? 32'h200 : 32'h100);
         tick();
         check("rr_r0_ready", ifa.r0_ready, !exp_own);
         check("rr_r1_ready", ifa.r1_ready, exp_own);
         check("rr_r0_rdata", ifa.r0_rdata, exp_own ? 32'h0 : 32'h5555_AAAA);
         check("rr_r1_rdata", ifa.r1_rdata, exp_own ? 32'h5555_AAAA : 32'h0);
         tick();
         check("rr_idle_busy", ifa.busy, 0);
         check("rr_idle_ready", ifa.r0_ready | ifa.r1_ready, 0);
      end
      ifa.r0_req = 0; ifa.r1_req = 0; ifa.bus_ack = 0;
      tick();

      // r1 write with 5 wait cycles; requester inputs scrambled after grant.
      ifa.r1_req = 1; ifa.r1_we = 1; ifa.r1_addr = 32'h0000_0300; ifa.r1_wdata = 32'h1234_5678;
      tick();
      ifa.r1_req = 0; ifa.r1_we = 0; ifa.r1_addr = 32'hFFFF_0000; ifa.r1_wdata = 32'h0BAD_0BAD;
      for (int i = 1; i <= 5; i++) begin
         check("ws_bus_en", ifa.bus_en, 1);
         check("ws_bus_we", ifa.bus_we, 1);
         check("ws_bus_addr", ifa.bus_addr, 32'h300);
         check("ws_bus_wdata", ifa.bus_wdata, 32'h1234_5678);
         check("ws_no_ready", ifa.r1_ready, 0);
         if (i == 5) ifa.bus_ack = 1;
         tick();
      end
      check("ws_ready", ifa.r1_ready, 1);
      check("ws_err", ifa.r1_err, 0);
      check("ws_rdata", ifa.r1_rdata, 0);
      check("ws_r0_ready", ifa.r0_ready, 0);
      check("ws_done_bus_en", ifa.bus_en, 0);
      ifa.bus_ack = 0;
      tick();

      // Timeout on instance B: 4 BUSY cycles then error.
      ifb.r0_req = 1; ifb.r0_we = 0; ifb.r0_addr = 32'h0000_0040; ifb.bus_rdata = 32'hFFFF_FFFF;
      tick();
      ifb.r0_req = 0;
      for (int i = 1; i <= 4; i++) begin
         check("to_bus_en", ifb.bus_en, 1);
         check("to_no_ready", ifb.r0_ready, 0);
         tick();
      end
      check("to_ready", ifb.r0_ready, 1);
      check("to_err", ifb.r0_err, 1);
      check("to_rdata", ifb.r0_rdata, 0);
      check("to_r1_err", ifb.r1_err, 0);
      check("to_bus_en_done", ifb.bus_en, 0);
      tick();

      // Ack on the timeout cycle: success.
      ifb.r0_req = 1;
      tick();
      ifb.r0_req = 0;
      for (int i = 1; i <= 4; i++) begin
         check("at_bus_en", ifb.bus_en, 1);
         if (i == 4) begin
            ifb.bus_ack = 1; ifb.bus_rdata = 32'hCAFE_F00D;
         end
         tick();
      end
      check("at_ready", ifb.r0_ready, 1);
      check("at_err", ifb.r0_err, 0);
      check("at_rdata", ifb.r0_rdata, 32'hCAFE_F00D);
      ifb.bus_ack = 0;
      tick();

      // Reset in the second BUSY cycle of an r0 access on instance A.
      ifa.r0_req = 1; ifa.r0_we = 0; ifa.r0_addr = 32'h0000_0500;
      tick();
      ifa.r0_req = 0;
      tick();
      check("mr_bus_en_busy2", ifa.bus_en, 1);
      rst = 1;
      tick();
      check("mr_bus_en", ifa.bus_en, 0);
      check("mr_busy", ifa.busy, 0);
      check("mr_ready", ifa.r0_ready, 0);
      rst = 0;
      tick();
      check("mr_no_pulse", ifa.r0_ready, 0);
      ifa.r0_req = 1; ifa.r1_req = 1;
      tick();
      check("mr_tie_owner", ifa.owner, 0);
      check("mr_tie_addr", ifa.bus_addr, 32'h500);
      ifa.r0_req = 0; ifa.r1_req = 0; ifa.bus_ack = 1;
      tick();
      check("mr_done_ready", ifa.r0_ready, 1);
      ifa.bus_ack = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
